// File: rtl/dm_arbiter_if.sv
// Bundle between the two masters, the dm_arbiter sequencer and the 1024 x 32 data memory.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface dm_arbiter_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_err;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output mem_addr, mem_wdata, mem_write, mem_read,
      input  mem_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  mem_addr, mem_wdata, mem_write, mem_read,
      output mem_rdata
   );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master round-robin sequencer for the data memory: IDLE -> ACCESS -> RESP,
// one memory access per transaction, all memory controls driven from registers.
module dm_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   dm_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state_q;
   logic              last_q;
   logic [1:0]        win_q;
   logic              we_q;
   logic              ok_q;
   logic [1:0]        gnt_q;
   logic [1:0]        rvalid_q;
   logic [1:0]        err_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_write_q;
   logic              mem_read_q;

   logic              win_d;
   logic              we_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic              ok_d;

   // Under contention the master that did not win last time goes first.
   always_comb begin
      win_d   = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
      we_d    = win_d ? bus.m1_we    : bus.m0_we;
      addr_d  = win_d ? bus.m1_addr  : bus.m0_addr;
      wdata_d = win_d ? bus.m1_wdata : bus.m0_wdata;
      ok_d    = addr_d < ADDR_W'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         win_q       <= 2'b00;
         we_q        <= 1'b0;
         ok_q        <= 1'b0;
         gnt_q       <= 2'b00;
         rvalid_q    <= 2'b00;
         err_q       <= 2'b00;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.m0_req || bus.m1_req) begin
                  win_q   <= win_d ? 2'b10 : 2'b01;
                  gnt_q   <= win_d ? 2'b10 : 2'b01;
                  we_q    <= we_d;
                  ok_q    <= ok_d;
                  // Out-of-range commands still get a grant but never touch the memory.
                  if (ok_d) begin
                     mem_addr_q  <= addr_d;
                     mem_wdata_q <= wdata_d;
                     mem_write_q <= we_d;
                     mem_read_q  <= ~we_d;
                  end
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               gnt_q       <= 2'b00;
               mem_write_q <= 1'b0;
               mem_read_q  <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               last_q      <= win_q[1];
               if (ok_q && !we_q) rvalid_q <= win_q;
               if (!ok_q)         err_q    <= win_q;
               state_q     <= RESP;
            end
            RESP: begin
               rvalid_q <= 2'b00;
               err_q    <= 2'b00;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.m0_gnt    = gnt_q[0];
   assign bus.m1_gnt    = gnt_q[1];
   assign bus.m0_rvalid = rvalid_q[0];
   assign bus.m1_rvalid = rvalid_q[1];
   assign bus.m0_err    = err_q[0];
   assign bus.m1_err    = err_q[1];
   // Memory read data arrives one cycle after the access edge, exactly in RESP.
   assign bus.m0_rdata  = rvalid_q[0] ? bus.mem_rdata : '0;
   assign bus.m1_rdata  = rvalid_q[1] ? bus.mem_rdata : '0;

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_read  = mem_read_q;

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Two-master arbiter/sequencer in front of the 1024 x 32 data memory.
- Master 0 is the CPU load/store path; master 1 is the debug/preload port.
- Each transaction is serialised into one memory access cycle. The memory's MemRead, MemWrite, address (result) and WriteData inputs are driven from registers, and ReadData is returned with a valid strobe.

Parameters:
- DATA_W, 32, data width of memory words and master data buses.
- ADDR_W, 32, width of master and memory address buses (word address).
- DEPTH, 1024, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- m0_req  in  1  master 0 request; held with its command until m0_gnt is seen.
- m0_we  in  1  master 0 command: 1 = write (sw), 0 = read (lw).
- m0_addr  in  ADDR_W  master 0 word address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  one-cycle pulse: command accepted.
- m0_rvalid  out  1  one-cycle pulse: read data valid (reads only).
- m0_rdata  out  DATA_W  read data; 0 when m0_rvalid is low.
- m0_err  out  1  one-cycle pulse: out-of-range address, no access performed.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical to master 0.
- mem_addr  out  ADDR_W  to memory address (result).
- mem_wdata  out  DATA_W  to memory WriteData.
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_rdata  in  DATA_W  from memory ReadData; valid in the cycle after the access edge.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. Reset forces state IDLE, all gnt/rvalid/err = 0, mem_write = mem_read = 0, mem_addr = mem_wdata = 0, rdata outputs = 0, last-winner pointer = 1 (so master 0 wins the first contention).
- FSM states: IDLE, ACCESS, RESP. Fixed latency; one transaction per 3 cycles max.
- IDLE: at posedge E0, if any req is high:
  - Pick the winner. Only one requesting: that one. Both requesting: the master that is not the last winner.
  - Register winner id, we and addr.
  - Range check: range_ok = (addr < DEPTH).
  - Go to ACCESS. No req: stay in IDLE.
- ACCESS (cycle after E0):
  - Winner's gnt = 1 for this cycle only.
  - If range_ok: mem_addr = registered addr; mem_write = we; mem_read = ~we; mem_wdata = registered wdata.
  - If not range_ok: mem_write = mem_read = 0.
  - The memory performs the access at posedge E1. Update the last-winner pointer at E1. Next state RESP.
- RESP (cycle after E1):
  - mem_write = mem_read = 0.
  - In-range read: winner's rvalid = 1, winner's rdata = mem_rdata.
  - In-range write: no rvalid.
  - Out of range: winner's err = 1, rdata = 0, rvalid = 0.
  - Next state IDLE at E2.
- Handshake: the master holds req/we/addr/wdata stable until gnt. It must drop or change req by the edge ending the gnt cycle (E1). A req still high at E2 is a new request.
- The loser keeps req high and is served next; no starvation under continuous contention.
- Exactly one of mem_write/mem_read is high, and only during ACCESS. Both are never high together. gnt, rvalid and err are never asserted for both masters in the same cycle.
- Address compare is unsigned over the full ADDR_W bits. No address wrap: 1024 and 0xFFFFFFFF are errors, not aliases of word 0.
- Reset mid-transaction (ACCESS or RESP) aborts it:
  - All outputs return to reset values asynchronously.
  - No gnt/rvalid/err pulse follows.
  - An in-flight write is not guaranteed to complete.
- A req change during ACCESS/RESP is ignored; the command is sampled only in IDLE.

Test Plan:
- Reset then m0 read addr 5 (memory preloaded mem[i] = i) -> m0_gnt 1 cycle after accept edge; mem_read high 1 cycle with mem_addr = 5; m0_rvalid next cycle with m0_rdata = 5; m1 outputs stay 0.
- m1 write addr 10 data 0xDEADBEEF, then m0 read addr 10 -> mem_write pulse with mem_wdata = 0xDEADBEEF; later m0_rdata = 0xDEADBEEF; no rvalid on the write.
- m0 and m1 both hold req continuously for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1; one transaction per 3 cycles; never simultaneous gnt.
- m0 read addr 1024, then m1 write addr 0xFFFFFFFF -> m0_err pulse, m0_rdata = 0, no mem_read; m1_err pulse, no mem_write; mem[0] and mem[1023] unchanged.
- rst_n asserted low during ACCESS of an m0 read -> mem_read drops immediately; no m0_rvalid or m0_err afterwards; after release, an m1 request is granted normally and m0 wins the next contention.
- m0 keeps req high after its gnt while m1 is idle -> back-to-back m0 transactions every 3 cycles; each one produces exactly one gnt and one rvalid.
